// File: rtl/led_cmd_sequencer.sv
// Command sequencer for a serial LED matrix driver: sends the init words after reset, then rows 1..8 from a shadow copy of the host buffer per frame.
// Each command waits for the driver's READY high -> low -> high handshake, so a stalled driver holds the sequencer in place.
module led_cmd_sequencer #(
   parameter logic [3:0] INTENSITY  = 4'h8,
   parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_wr_en,
   input  logic [2:0]  in_wr_addr,
   input  logic [7:0]  in_wr_data,
   input  logic        in_refresh,
   input  logic        in_IR_READY,
   output logic        out_IR_START,
   output logic [15:0] out_word,
   output logic        out_busy,
   output logic        out_frame_done
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] INIT      = 3'd1;
   localparam logic [2:0] SNAP      = 3'd2;
   localparam logic [2:0] SEND      = 3'd3;
   localparam logic [2:0] WAIT_ACK  = 3'd4;
   localparam logic [2:0] WAIT_DONE = 3'd5;

   logic [2:0]  state;
   logic [2:0]  idx;
   logic [2:0]  idx_nxt;
   logic        init_phase;
   logic        init_req;
   logic        pending;
   logic        last_cmd;
   logic [15:0] word;
   logic [15:0] word_nxt;
   logic        frame_done;
   logic [7:0]  host   [8];
   logic [7:0]  shadow [8];

   function automatic logic [15:0] init_word(input logic [2:0] i);
      case (i)
         3'd0:    return 16'h0C00;
         3'd1:    return 16'h0900;
         3'd2:    return {8'h0A, 4'h0, INTENSITY};
         3'd3:    return {8'h0B, 5'h00, SCAN_LIMIT};
         3'd4:    return 16'h0F00;
         default: return 16'h0C01;
      endcase
   endfunction

   function automatic logic [15:0] row_word(input logic [2:0] i, input logic [7:0] d);
      return {8'h01 + {5'd0, i}, d};
   endfunction

   assign idx_nxt  = idx + 3'd1;
   assign last_cmd = init_phase ? (idx == 3'd5) : (idx == 3'd7);
   assign word_nxt = init_phase ? init_word(idx_nxt) : row_word(idx_nxt, shadow[idx_nxt]);

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         for (int i = 0; i < 8; i++) host[i] <= 8'h00;
      end else if (in_wr_en) begin
         host[in_wr_addr] <= in_wr_data;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state      <= IDLE;
         idx        <= 3'd0;
         init_phase <= 1'b0;
         init_req   <= 1'b1;
         pending    <= 1'b0;
         word       <= 16'h0000;
         frame_done <= 1'b0;
         for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
      end else begin
         frame_done <= 1'b0;
         // Any refresh outside IDLE collapses into one follow-on frame; the frame-end branch below consumes it.
         if (in_refresh && (state != IDLE || init_req)) pending <= 1'b1;
         case (state)
            IDLE: begin
               if (init_req)        state <= INIT;
               else if (in_refresh) state <= SNAP;
            end
            INIT: begin
               init_req   <= 1'b0;
               init_phase <= 1'b1;
               idx        <= 3'd0;
               word       <= init_word(3'd0);
               state      <= SEND;
            end
            SNAP: begin
               for (int i = 0; i < 8; i++) shadow[i] <= host[i];
               init_phase <= 1'b0;
               idx        <= 3'd0;
               word       <= row_word(3'd0, host[0]);
               state      <= SEND;
            end
            SEND: begin
               if (in_IR_READY) state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (!in_IR_READY) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (in_IR_READY) begin
                  if (!last_cmd) begin
                     idx   <= idx_nxt;
                     word  <= word_nxt;
                     state <= SEND;
                  end else if (init_phase) begin
                     state <= SNAP;
                  end else begin
                     frame_done <= 1'b1;
                     if (pending || in_refresh) begin
                        pending <= 1'b0;
                        state   <= SNAP;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // START is combinational so it can never be high while READY is low.
   assign out_IR_START   = (state == SEND) && in_IR_READY;
   assign out_word       = word;
   assign out_busy       = (state != IDLE);
   assign out_frame_done = frame_done;

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Directed bench: driver model drops READY for 3 cycles after each START; captured command words are compared to hand-written lists.
module tb_led_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [7:0]  wr_data = 8'h00;
   logic        refresh = 1'b0;
   logic        drv_ready = 1'b1;
   logic        hold_low = 1'b0;
   wire         ir_ready = drv_ready & ~hold_low;
   logic        ir_start;
   logic [15:0] word;
   logic        busy;
   logic        frame_done;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          fd_count = 0;
   int          viol = 0;
   int          first_start_cyc = -1;
   logic [15:0] words[$];

   led_cmd_sequencer #(.INTENSITY(4'h8), .SCAN_LIMIT(3'd7)) dut (
      .in_clk(clk), .in_rst(rst), .in_wr_en(wr_en), .in_wr_addr(wr_addr),
      .in_wr_data(wr_data), .in_refresh(refresh), .in_IR_READY(ir_ready),
      .out_IR_START(ir_start), .out_word(word), .out_busy(busy),
      .out_frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Driver model and monitor: READY update first, then sample outputs after it settles.
   initial begin
      logic drop;
      int   cnt;
      drop = 1'b0;
      cnt  = 0;
      forever begin
         @(negedge clk);
         if (drop) begin
            drv_ready = 1'b0;
            cnt       = 3;
            drop      = 1'b0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) drv_ready = 1'b1;
         end
         #1;
         if (ir_start) begin
            if (!ir_ready || !rst) viol++;
            if (first_start_cyc < 0) first_start_cyc = cyc;
            words.push_back(word);
            drop = 1'b1;
         end
         if (frame_done) fd_count++;
      end
   end

   function automatic logic [31:0] wget(input int i);
      if (i < words.size()) return {16'h0000, words[i]};
      return 32'hFFFF_FFFF;
   endfunction

   task automatic wait_words(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && words.size() < n; i++) begin
         @(negedge clk);
         #2;
      end
      chk(tag, words.size(), n);
   endtask

   task automatic wait_fd(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && fd_count < n; i++) begin
         @(negedge clk);
         #2;
      end
      chk(tag, fd_count, n);
   endtask

   task automatic pulse_refresh();
      @(posedge clk); #1 refresh = 1'b1;
      @(posedge clk); #1 refresh = 1'b0;
   endtask

   task automatic write_row(input logic [2:0] a, input logic [7:0] d);
      @(posedge clk); #1 wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1 wr_en = 1'b0;
   endtask

   task automatic chk_frame(input string tag, input int base, input logic [7:0] r0, input logic [7:0] r3, input logic [7:0] r7);
      logic [7:0] rows [8];
      logic [7:0] addr;
      for (int i = 0; i < 8; i++) rows[i] = 8'h00;
      rows[0] = r0;
      rows[3] = r3;
      rows[7] = r7;
      for (int i = 0; i < 8; i++) begin
         addr = 8'(i + 1);
         chk($sformatf("%s_w%0d", tag, i), wget(base + i), {16'h0000, addr, rows[i]});
      end
   endtask

   initial begin
      logic [15:0] init_exp [6];
      int          fd0;
      int          busy_low;
      int          rel_cyc;
      init_exp = '{16'h0C00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0F00, 16'h0C01};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", ir_start, 0);
      chk("rst_word", word, 16'h0000);
      chk("rst_busy", busy, 0);
      chk("rst_fdone", frame_done, 0);

      // Init sequence and automatic first frame
      @(posedge clk); #1 rst = 1'b1;
      rel_cyc = cyc;
      wait_fd(1, 1000, "init_fd");
      chk("first_start_gap_ok", (first_start_cyc - rel_cyc) >= 2, 1);
      chk("init_nwords", words.size(), 14);
      for (int i = 0; i < 6; i++) chk($sformatf("init_w%0d", i), wget(i), {16'h0000, init_exp[i]});
      chk_frame("f0", 6, 8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      #2;
      chk("idle_busy", busy, 0);

      // Host rows then refresh from IDLE; busy must stay high across the frame
      words.delete();
      write_row(3'd3, 8'hA5);
      write_row(3'd7, 8'h3C);
      pulse_refresh();
      busy_low = 0;
      for (int i = 0; i < 500 && fd_count < 2; i++) begin
         @(negedge clk);
         #2;
         if (!frame_done && !busy) busy_low++;
      end
      chk("f1_fd", fd_count, 2);
      chk("f1_busy_low", busy_low, 0);
      chk("f1_nwords", words.size(), 8);
      chk_frame("f1", 0, 8'h00, 8'hA5, 8'h3C);

      // Host write and two refreshes during a frame: one follow-on frame only
      words.delete();
      pulse_refresh();
      wait_words(1, 200, "f2_first");
      write_row(3'd0, 8'hFF);
      pulse_refresh();
      repeat (5) @(posedge clk);
      pulse_refresh();
      wait_fd(4, 1000, "f2_fd");
      repeat (40) @(negedge clk);
      #2;
      chk("f2_no_extra_fd", fd_count, 4);
      chk("f2_nwords", words.size(), 16);
      chk_frame("f2a", 0, 8'h00, 8'hA5, 8'h3C);
      chk_frame("f2b", 8, 8'hFF, 8'hA5, 8'h3C);

      // READY held low in SEND stalls without a START
      words.delete();
      @(posedge clk); #1 hold_low = 1'b1;
      pulse_refresh();
      repeat (50) @(negedge clk);
      #2;
      chk("stall_nstart", words.size(), 0);
      chk("stall_word", word, 16'h01FF);
      chk("stall_busy", busy, 1);
      @(posedge clk); #1 hold_low = 1'b0;
      wait_fd(5, 500, "stall_fd");
      chk("stall_nwords", words.size(), 8);
      chk("stall_w0", wget(0), 32'h0000_01FF);

      // Reset during WAIT_DONE of row 4
      words.delete();
      pulse_refresh();
      wait_words(5, 300, "rst_row4_seen");
      chk("rst_row4_word", wget(4), 32'h0000_0500);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_start", ir_start, 0);
      chk("arst_word", word, 16'h0000);
      chk("arst_busy", busy, 0);
      chk("arst_fdone", frame_done, 0);
      repeat (10) @(posedge clk);
      chk("arst_nwords", words.size(), 5);
      words.delete();
      fd0 = fd_count;
      @(posedge clk); #1 rst = 1'b1;
      wait_fd(fd0 + 1, 1000, "rerun_fd");
      chk("rerun_nwords", words.size(), 14);
      chk("rerun_w0", wget(0), 32'h0000_0C00);
      chk_frame("rerun", 6, 8'h00, 8'h00, 8'h00);

      // Refresh exactly on the final WAIT_DONE exit
      words.delete();
      fd0 = fd_count;
      pulse_refresh();
      wait_words(8, 300, "edge_last_seen");
      repeat (4) @(posedge clk);
      #1 refresh = 1'b1;
      @(posedge clk); #1 refresh = 1'b0;
      @(negedge clk); #2;
      chk("edge_fdone", frame_done, 1);
      chk("edge_busy", busy, 1);
      wait_fd(fd0 + 2, 500, "edge_fd");
      chk("edge_nwords", words.size(), 16);
      chk("edge_w8", wget(8), 32'h0000_0100);

      chk("start_protocol", viol, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
